// File: rtl/operational_unit_pkg.sv
// ---------------------------------------------------------------------------
// operational_unit_pkg
// Shared definitions for the operational unit datapath: the control-word
// width shared with the control unit and microcode generator, the bit
// offsets/widths of every control-word field, and the ALU opcode encoding.
// ---------------------------------------------------------------------------
package operational_unit_pkg;

  localparam int CONTROL_WIDTH = 17;

  localparam int ALU_OP_LSB  = 14;
  localparam int ALU_OP_W    = 3;
  localparam int A_SEL_LSB   = 12;
  localparam int A_SEL_W     = 2;
  localparam int B_SEL_LSB   = 10;
  localparam int B_SEL_W     = 2;
  localparam int DST_LSB     = 8;
  localparam int DST_W       = 2;
  localparam int REG_WE_BIT  = 7;
  localparam int FLAG_WE_BIT = 6;
  localparam int B_IMM_BIT   = 5;
  localparam int B_IN_BIT    = 4;
  localparam int OUT_WE_BIT  = 3;
  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = 3;

  localparam int NUM_REGS    = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_PASS = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_OR   = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_SHL  = 3'b110,
    ALU_SHR  = 3'b111
  } aluOp_t;

endpackage

// File: rtl/operational_unit_if.sv
// ---------------------------------------------------------------------------
// operational_unit_if
// Bundles the control-unit-facing signals of the operational unit.
//   control_bus    : micro-operation word from the control unit
//   data_in        : external operand
//   data_out       : registered output port
//   data_out_valid : one-cycle strobe after data_out is loaded
//   carry_flag     : registered carry/borrow flag
//   zero_flag      : registered zero flag
// master = control side (drives control_bus/data_in), slave = datapath.
// ---------------------------------------------------------------------------
interface operational_unit_if
  import operational_unit_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic [CONTROL_WIDTH-1:0] control_bus;
  logic [WIDTH-1:0]         data_in;
  logic [WIDTH-1:0]         data_out;
  logic                     data_out_valid;
  logic                     carry_flag;
  logic                     zero_flag;

  modport master (
    output control_bus,
    output data_in,
    input  data_out,
    input  data_out_valid,
    input  carry_flag,
    input  zero_flag
  );

  modport slave (
    input  control_bus,
    input  data_in,
    output data_out,
    output data_out_valid,
    output carry_flag,
    output zero_flag
  );

endinterface

// File: rtl/operational_unit_alu.sv
// ---------------------------------------------------------------------------
// arithmetic_logic_unit
// Purely combinational WIDTH-bit unsigned ALU.
//   a, b   : operands
//   op     : operation select (aluOp_t)
//   result : WIDTH-bit wrap-around result
//   carry  : carry out for ADD, borrow for SUB, shifted-out bit for
//            SHL/SHR, zero for PASS and the logic operations
// ---------------------------------------------------------------------------
module arithmetic_logic_unit
  import operational_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  aluOp_t           op,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] w_sum;

  // The extra top bit of the widened sum is the carry out of bit WIDTH-1.
  assign w_sum = {1'b0, a} + {1'b0, b};

  // Select the result and carry for the requested operation. The borrow for
  // SUB is taken from an unsigned compare rather than the subtractor so it
  // reads directly as "A is smaller than B".
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_PASS: result = b;
      ALU_ADD: begin
        result = w_sum[WIDTH-1:0];
        carry  = w_sum[WIDTH];
      end
      ALU_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      ALU_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/operational_unit.sv
// ---------------------------------------------------------------------------
// operational_unit
// Datapath counterpart of the microprogrammed control unit. Executes one
// register-transfer micro-operation per clock on a 4-entry register file.
//   clock : rising-edge system clock
//   reset : asynchronous active-high, clears registers, flags and output
//   bus   : operational_unit_if.slave (control_bus, data_in in;
//           data_out, data_out_valid, carry_flag, zero_flag out)
// An all-zero control word has every write enable clear, so it is a NOP.
// ---------------------------------------------------------------------------
module operational_unit
  import operational_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  operational_unit_if.slave        bus
);

  logic [WIDTH-1:0] r_regFile [NUM_REGS];
  logic [WIDTH-1:0] r_dataOut;
  logic             r_dataOutValid;
  logic             r_carryFlag;
  logic             r_zeroFlag;

  aluOp_t           w_aluOp;
  logic [1:0]       w_aSel;
  logic [1:0]       w_bSel;
  logic [1:0]       w_dst;
  logic             w_regWe;
  logic             w_flagWe;
  logic             w_bImm;
  logic             w_bIn;
  logic             w_outWe;
  logic [IMM_W-1:0] w_imm;
  logic [WIDTH-1:0] w_operandA;
  logic [WIDTH-1:0] w_operandB;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;

  // Split the control word into its fields.
  assign w_aluOp  = aluOp_t'(bus.control_bus[ALU_OP_LSB +: ALU_OP_W]);
  assign w_aSel   = bus.control_bus[A_SEL_LSB +: A_SEL_W];
  assign w_bSel   = bus.control_bus[B_SEL_LSB +: B_SEL_W];
  assign w_dst    = bus.control_bus[DST_LSB +: DST_W];
  assign w_regWe  = bus.control_bus[REG_WE_BIT];
  assign w_flagWe = bus.control_bus[FLAG_WE_BIT];
  assign w_bImm   = bus.control_bus[B_IMM_BIT];
  assign w_bIn    = bus.control_bus[B_IN_BIT];
  assign w_outWe  = bus.control_bus[OUT_WE_BIT];
  assign w_imm    = bus.control_bus[IMM_LSB +: IMM_W];

  // Register reads are combinational, so a same-cycle source that equals
  // the destination sees the value from before this edge's write.
  assign w_operandA = r_regFile[w_aSel];

  // Operand B priority: external data_in, then zero-extended immediate,
  // then the register file.
  always_comb begin
    w_operandB = r_regFile[w_bSel];
    if (w_bIn) begin
      w_operandB = bus.data_in;
    end else if (w_bImm) begin
      w_operandB = {{(WIDTH-IMM_W){1'b0}}, w_imm};
    end
  end

  arithmetic_logic_unit #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (w_operandA),
    .b      (w_operandB),
    .op     (w_aluOp),
    .result (w_result),
    .carry  (w_carry)
  );

  // All architectural state updates on one edge: the register write, the
  // flag update and the output latch all see the same pre-edge operands.
  // The flags are only ever loaded here, so they never depend
  // combinationally on control_bus. zero_flag clears to 0 on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regFile[i] <= '0;
      end
      r_dataOut      <= '0;
      r_dataOutValid <= 1'b0;
      r_carryFlag    <= 1'b0;
      r_zeroFlag     <= 1'b0;
    end else begin
      if (w_regWe) begin
        r_regFile[w_dst] <= w_result;
      end
      if (w_flagWe) begin
        r_carryFlag <= w_carry;
        r_zeroFlag  <= (w_result == '0);
      end
      if (w_outWe) begin
        r_dataOut <= w_operandA;
      end
      r_dataOutValid <= w_outWe;
    end
  end

  assign bus.data_out       = r_dataOut;
  assign bus.data_out_valid = r_dataOutValid;
  assign bus.carry_flag     = r_carryFlag;
  assign bus.zero_flag      = r_zeroFlag;

endmodule

// File: tb/tb_operational_unit.sv
// ---------------------------------------------------------------------------
// tb_operational_unit
// Scoreboarded bench for operational_unit (WIDTH=8). Each applied control
// word advances a reference model written from the micro-operation rules and
// pushes the expected post-edge outputs; a monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_operational_unit;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  typedef struct {
    int valid;
    int dout;
    int carry;
    int zero;
  } expect_t;

  logic clock;
  logic reset;

  operational_unit_if #(.WIDTH(W)) bus ();

  operational_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  expect_t expQ[$];
  int      vectors;
  int      miscompares;

  int      mReg[4];
  int      mDout;
  int      mValid;
  int      mCarry;
  int      mZero;

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Assemble a control word from its fields.
  function automatic logic [16:0] makeCw(input int op, input int aSel,
                                         input int bSel, input int dst,
                                         input int regWe, input int flagWe,
                                         input int bImm, input int bIn,
                                         input int outWe, input int imm);
    logic [16:0] cw;
    cw        = '0;
    cw[16:14] = op[2:0];
    cw[13:12] = aSel[1:0];
    cw[11:10] = bSel[1:0];
    cw[9:8]   = dst[1:0];
    cw[7]     = regWe[0];
    cw[6]     = flagWe[0];
    cw[5]     = bImm[0];
    cw[4]     = bIn[0];
    cw[3]     = outWe[0];
    cw[2:0]   = imm[2:0];
    return cw;
  endfunction

  // Reference model: one micro-operation in plain integer arithmetic.
  task automatic modelStep(input logic [16:0] cw, input int din);
    int op, a, b, res, c, s;
    op = int'(cw[16:14]);
    a  = mReg[cw[13:12]];
    if (cw[4])      b = din;
    else if (cw[5]) b = int'(cw[2:0]);
    else            b = mReg[cw[11:10]];
    c = 0;
    case (op)
      0: res = b;
      1: begin s = a + b; res = s % MOD; c = (s >= MOD) ? 1 : 0; end
      2: begin res = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; end
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: begin s = a * 2; res = s % MOD; c = (s >= MOD) ? 1 : 0; end
      default: begin res = a / 2; c = a % 2; end
    endcase
    if (cw[3]) begin
      mDout  = a;
      mValid = 1;
    end else begin
      mValid = 0;
    end
    if (cw[7]) mReg[cw[9:8]] = res;
    if (cw[6]) begin
      mCarry = c;
      mZero  = (res == 0) ? 1 : 0;
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mReg[i] = 0;
    mDout  = 0;
    mValid = 0;
    mCarry = 0;
    mZero  = 0;
  endtask

  task automatic checkOutput(input string name, input int actual,
                             input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Drive one control word between edges and queue the expected result.
  task automatic applyStimulus(input logic [16:0] cw, input int din);
    expect_t e;
    @(negedge clock);
    bus.control_bus = cw;
    bus.data_in     = din[W-1:0];
    modelStep(cw, din);
    e.valid = mValid;
    e.dout  = mDout;
    e.carry = mCarry;
    e.zero  = mZero;
    expQ.push_back(e);
  endtask

  // Monitor: just after every edge, compare the DUT to the oldest entry.
  initial begin
    expect_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("data_out_valid", int'(bus.data_out_valid), e.valid);
        checkOutput("data_out", int'(bus.data_out), e.dout);
        checkOutput("carry_flag", int'(bus.carry_flag), e.carry);
        checkOutput("zero_flag", int'(bus.zero_flag), e.zero);
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " data_out"}, int'(bus.data_out), 0);
    checkOutput({tag, " data_out_valid"}, int'(bus.data_out_valid), 0);
    checkOutput({tag, " carry_flag"}, int'(bus.carry_flag), 0);
    checkOutput({tag, " zero_flag"}, int'(bus.zero_flag), 0);
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    vectors     = 0;
    miscompares = 0;
    modelReset();
    bus.control_bus = '0;
    bus.data_in     = '0;
    reset           = 1'b1;
    #12;
    checkAllZero("reset");
    @(negedge clock);
    reset = 1'b0;

    // Load R1=5, read it out, then pulse reset between edges.
    applyStimulus(makeCw(0, 0, 0, 1, 1, 0, 1, 0, 0, 5), 0);
    applyStimulus(makeCw(0, 1, 0, 0, 0, 0, 0, 0, 1, 0), 0);
    @(negedge clock);
    bus.control_bus = '0;
    #2 reset = 1'b1;
    #1 checkAllZero("midreset");
    #1 reset = 1'b0;
    modelReset();
    applyStimulus(makeCw(0, 1, 0, 0, 0, 0, 0, 0, 1, 0), 0);

    // Immediate / data_in / ADD with carry out.
    applyStimulus(makeCw(0, 0, 0, 0, 1, 0, 1, 0, 0, 7), 0);
    applyStimulus(makeCw(0, 0, 0, 1, 1, 0, 0, 1, 0, 0), 'hFA);
    applyStimulus(makeCw(1, 1, 0, 2, 1, 1, 0, 0, 0, 0), 0);
    applyStimulus(makeCw(0, 2, 0, 0, 0, 0, 0, 0, 1, 0), 0);

    // SUB giving zero, then SUB with borrow.
    applyStimulus(makeCw(0, 0, 0, 0, 1, 0, 1, 0, 0, 3), 0);
    applyStimulus(makeCw(0, 0, 0, 1, 1, 0, 1, 0, 0, 3), 0);
    applyStimulus(makeCw(2, 1, 0, 0, 0, 1, 0, 0, 0, 0), 0);
    applyStimulus(makeCw(0, 0, 0, 2, 1, 0, 1, 0, 0, 4), 0);
    applyStimulus(makeCw(2, 0, 2, 3, 1, 1, 0, 0, 0, 0), 0);
    applyStimulus(makeCw(0, 3, 0, 0, 0, 0, 0, 0, 1, 0), 0);

    // Flags now c=1,z=0; three NOPs must hold everything.
    for (int i = 0; i < 3; i++) applyStimulus('0, $urandom_range(0, 255));
    applyStimulus(makeCw(0, 3, 0, 0, 0, 0, 0, 0, 1, 0), 0);

    // Shift sequence from 0x81.
    applyStimulus(makeCw(0, 0, 0, 0, 1, 0, 0, 1, 0, 0), 'h81);
    applyStimulus(makeCw(6, 0, 0, 0, 1, 1, 0, 0, 0, 0), 0);
    applyStimulus(makeCw(7, 0, 0, 0, 1, 1, 0, 0, 0, 0), 0);
    applyStimulus(makeCw(7, 0, 0, 0, 1, 1, 0, 0, 0, 0), 0);

    // Same-cycle read of the destination plus output strobe.
    applyStimulus(makeCw(0, 0, 0, 0, 1, 0, 0, 1, 0, 0), 9);
    applyStimulus(makeCw(1, 0, 0, 0, 1, 0, 1, 0, 1, 1), 0);
    applyStimulus('0, 0);
    applyStimulus(makeCw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0);

    // Randomized control words, with occasional NOPs.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0)
        applyStimulus('0, $urandom_range(0, 255));
      else
        applyStimulus(17'($urandom), $urandom_range(0, 255));
    end

    // Let the monitor drain, bounded.
    @(negedge clock);
    bus.control_bus = '0;
    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clock);
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operational_unit.md
Name: operational_unit

Overview:
- Datapath counterpart of the microprogrammed control unit.
- Consumes the 17-bit control bus emitted each cycle, executes one register-transfer micro-operation per clock on a 4-entry register file through an ALU, and returns registered carry_flag/zero_flag that drive the control unit's conditional jumps.
- An all-zero control word (emitted during jump commands) is a strict NOP.

Parameters:
- WIDTH, 8, datapath and register width in bits (min 4).

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high; clears all state immediately
- control_bus  input  17  micro-operation word, field map below
- data_in  input  WIDTH  external operand, selectable as ALU operand B
- data_out  output  WIDTH  registered output port
- data_out_valid  output  1  one-cycle strobe, high the cycle after data_out is loaded
- carry_flag  output  1  registered carry/borrow flag
- zero_flag  output  1  registered zero flag

Behaviour:
- Control word fields:
  - [16:14] alu_op
  - [13:12] a_sel
  - [11:10] b_sel
  - [9:8] dst
  - [7] reg_we
  - [6] flag_we
  - [5] b_imm
  - [4] b_in
  - [3] out_we
  - [2:0] imm
- Operand A = R[a_sel].
- Operand B:
  - data_in if b_in=1 (b_in takes priority over b_imm)
  - else zero-extended imm if b_imm=1
  - else R[b_sel].
- Register reads are combinational. A write lands at the rising edge, so same-cycle source==dst reads the old value.
- alu_op and carry out:
  - 000 PASS B: result=B, c=0
  - 001 ADD: A+B, c=carry out of bit WIDTH-1
  - 010 SUB: A-B mod 2^WIDTH, c=1 iff A<B unsigned (borrow)
  - 011 AND: c=0
  - 100 OR: c=0
  - 101 XOR: c=0
  - 110 SHL: A<<1, c=A[WIDTH-1]
  - 111 SHR: A>>1 (logical), c=A[0]
- All arithmetic is WIDTH-bit, wrap-around, unsigned.
- reg_we=1: R[dst] <= result at the edge.
- flag_we=1: carry_flag <= c and zero_flag <= (result==0) at the same edge. Otherwise the flags hold.
- reg_we and flag_we may both be set; both take the same result.
- out_we=1: data_out <= R[a_sel] (pre-write value) and data_out_valid <= 1 next cycle. Otherwise data_out_valid <= 0 and data_out holds.
- Latency: one clock from control word to register, flag and output update.
- Flag timing: a flag-setting word at cycle k gives flags valid at cycle k+1, where a branch word in the control unit samples them. Flags are never combinational from control_bus.
- Reset (asynchronous, any time, including mid-sequence):
  - R0..R3=0, carry_flag=0, zero_flag=0, data_out=0, data_out_valid=0.
  - zero_flag resets to 0, not 1.
- First edge after reset release executes the current control_bus normally.
- control_bus=0: result=R-file B path, no state changes, data_out_valid=0.

Decomposition:
- Shared package/header:
  - ALU opcode constants (ALU_PASS..ALU_SHR)
  - control-word field offsets/widths
  - CONTROL_WIDTH=17 (shared with the control unit and the microcode generator)
- One combinational sub-module, arithmetic_logic_unit (WIDTH param; inputs a, b, op; outputs result, carry). The top holds the register file, operand muxes, flag and output registers.

Test Plan:
- Reset mid-run: load R1=5, pulse reset between edges -> all outputs 0 immediately; R1 reads back 0 via out_we.
- Immediate/ADD, WIDTH=8: R0<=imm 7; R1<=data_in 0xFA; ADD R2=R1+R0 with flag_we -> R2=0x01, carry_flag=1, zero_flag=0 the next cycle.
- SUB borrow/zero:
  - R0=3, R1=3: SUB R1-R0 with flag_we -> zero=1, carry=0.
  - R0-R2 with R2=4 -> result 0xFF, carry=1, zero=0.
- Flag hold and NOP: set flags (c=1, z=0), then 3 cycles of control_bus=0 -> flags, registers and data_out unchanged; data_out_valid=0.
- Shifts: R0=0x81; SHL with flag_we -> 0x02, carry=1; SHR of 0x02 -> 0x01, carry=0; SHR of 0x01 -> 0x00, zero=1, carry=1.
- Same-cycle hazard and output: ADD dst=R0, a_sel=0, b_imm=1, imm=1 with out_we=1 and R0=9 -> data_out=9 (old value), R0=10; data_out_valid high exactly one cycle.
